// File: rtl/screen_mem_arbiter.sv
// Shares the single-ported 2 KB system RAM between the 6502 core and the screen fetch port.
// Video takes the port at an opcode fetch (or after a bounded wait) and the stalled fetch is replayed on hand-back.
module screen_mem_arbiter #(
    parameter int MAX_WAIT = 12
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] cpu_addr,
    input  logic        cpu_we,
    input  logic [7:0]  cpu_dout,
    input  logic        cpu_sync,
    output logic [7:0]  cpu_din,
    output logic        cpu_rdy,
    input  logic        vid_req,
    input  logic [10:0] vid_addr,
    output logic [7:0]  vid_data,
    output logic        vid_grant,
    output logic [10:0] mem_addr,
    output logic        mem_we,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata
);

    localparam logic [1:0] ST_CPU_OWN   = 2'd0;
    localparam logic [1:0] ST_WAIT_SYNC = 2'd1;
    localparam logic [1:0] ST_VID_OWN   = 2'd2;
    localparam logic [1:0] ST_RETURN    = 2'd3;

    localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

    logic [1:0] state_r;
    logic [1:0] state_next_s;
    logic [3:0] wait_cnt_r;
    logic [3:0] wait_cnt_next_s;
    logic       vid_grant_r;
    logic       grant_now_s;
    logic       cpu_in_ram_s;

    // Writes above the 2 KB window never reach the RAM.
    assign cpu_in_ram_s = (cpu_addr[15:11] == 5'd0);

    // A write cycle is never interrupted, so the handover waits for cpu_we low.
    assign grant_now_s = (state_r == ST_WAIT_SYNC) && vid_req && !cpu_we &&
                         (cpu_sync || (wait_cnt_r == MAX_WAIT_C));

    assign cpu_din   = mem_rdata;
    assign vid_data  = mem_rdata;
    assign mem_wdata = cpu_dout;
    assign vid_grant = vid_grant_r;

    // Next-state and wait-counter decode.
    always_comb begin
        state_next_s    = state_r;
        wait_cnt_next_s = 4'd0;
        case (state_r)
            ST_CPU_OWN: begin
                if (vid_req) begin
                    state_next_s = ST_WAIT_SYNC;
                end else begin
                    state_next_s = ST_CPU_OWN;
                end
            end
            ST_WAIT_SYNC: begin
                if (!vid_req) begin
                    state_next_s = ST_CPU_OWN;
                end else if (grant_now_s) begin
                    state_next_s = ST_VID_OWN;
                end else begin
                    state_next_s = ST_WAIT_SYNC;
                    // Saturate so a long write keeps the timeout condition armed.
                    if (wait_cnt_r == MAX_WAIT_C) begin
                        wait_cnt_next_s = wait_cnt_r;
                    end else begin
                        wait_cnt_next_s = wait_cnt_r + 4'd1;
                    end
                end
            end
            ST_VID_OWN: begin
                if (vid_req) begin
                    state_next_s = ST_VID_OWN;
                end else begin
                    state_next_s = ST_RETURN;
                end
            end
            ST_RETURN: begin
                state_next_s = ST_CPU_OWN;
            end
            default: begin
                state_next_s = ST_CPU_OWN;
            end
        endcase
    end

    // RAM port steering and CPU stall decode.
    always_comb begin
        mem_addr = cpu_addr[10:0];
        mem_we   = cpu_we & cpu_in_ram_s;
        cpu_rdy  = 1'b1;
        case (state_r)
            ST_CPU_OWN: begin
                mem_addr = cpu_addr[10:0];
                mem_we   = cpu_we & cpu_in_ram_s;
                cpu_rdy  = 1'b1;
            end
            ST_WAIT_SYNC: begin
                // The fetch in the grant cycle is stalled and replayed in RETURN.
                mem_addr = cpu_addr[10:0];
                mem_we   = cpu_we & cpu_in_ram_s;
                cpu_rdy  = !grant_now_s;
            end
            ST_VID_OWN: begin
                mem_addr = vid_addr;
                mem_we   = 1'b0;
                cpu_rdy  = 1'b0;
            end
            ST_RETURN: begin
                mem_addr = cpu_addr[10:0];
                mem_we   = 1'b0;
                cpu_rdy  = 1'b0;
            end
            default: begin
                mem_addr = cpu_addr[10:0];
                mem_we   = cpu_we & cpu_in_ram_s;
                cpu_rdy  = 1'b1;
            end
        endcase
    end

    // State, wait counter and grant flag registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_CPU_OWN;
            wait_cnt_r  <= 4'd0;
            vid_grant_r <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            wait_cnt_r  <= wait_cnt_next_s;
            vid_grant_r <= (state_next_s == ST_VID_OWN);
        end
    end

endmodule
